// File: rtl/ab_write_sink.sv
// ab_write_sink
//   Device-side responder for the host's paired load streams. Address beats
//   arrive on A, data beats on B; each A beat pairs in order with one B beat.
//   A pair becomes one registered write to the feature memory and/or the
//   overlap cache. The load phase ends with a single-cycle load_done pulse.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_input/a_valid/a_ready   address beat stream
//   int_mem_we, overlap_cache_we  target flags, sampled with each A beat
//   b_input/b_valid/b_ready   data beat stream
//   data_ready                host level: no more beats, start the drain
//   wr_valid/wr_ready         downstream write handshake
//   wr_addr, wr_data          write address / data
//   wr_mem, wr_cache          write targets
//   load_done                 one-cycle end-of-load pulse
//   pair_count                pairs consumed since reset (saturating)
//   addr_err, unpaired_err    sticky error flags

// Two-entry FIFO with a synchronous flush. Push and pop may share an edge.
module ab_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   logic [1:0][W-1:0] mem;
   logic              wptr;
   logic              rptr;
   logic [1:0]        cnt;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         mem  <= '0;
         wptr <= 1'b0;
         rptr <= 1'b0;
         cnt  <= 2'd0;
      end else begin
         if (push) begin
            mem[wptr] <= din;
            wptr      <= !wptr;
         end
         if (pop) rptr <= !rptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem[rptr];
   assign empty = (cnt == 2'd0);
   assign full  = (cnt == 2'd2);
endmodule

module ab_write_sink #(
   parameter int DATA_WIDTH = 16,
   parameter int MEM_DEPTH  = 1024,
   parameter int CNT_WIDTH  = 16,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a_input,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [DATA_WIDTH-1:0] b_input,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic                  int_mem_we,
   input  logic                  overlap_cache_we,
   input  logic                  data_ready,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [AW-1:0]         wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_mem,
   output logic                  wr_cache,
   output logic                  load_done,
   output logic [CNT_WIDTH-1:0]  pair_count,
   output logic                  addr_err,
   output logic                  unpaired_err
);
   typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;

   // A entry: {out_of_range, cache_we, mem_we, addr}. The range check is done
   // on the full beat at push time so only AW address bits need storing.
   typedef struct packed {
      logic          oob;
      logic          cache;
      logic          mem;
      logic [AW-1:0] addr;
   } a_ent_t;

   localparam logic [DATA_WIDTH:0] DEPTH_V = (DATA_WIDTH+1)'(MEM_DEPTH);

   state_t                state;
   a_ent_t                a_din, a_head;
   logic [DATA_WIDTH-1:0] b_head;
   logic                  a_empty, a_full, b_empty, b_full;
   logic                  a_push, b_push, pop;
   logic                  flush_a, flush_b;

   // Readies depend only on reset, state and occupancy, never on the valids.
   assign a_ready = !rst && (state == LOAD) && !a_full;
   assign b_ready = !rst && (state == LOAD) && !b_full;
   assign a_push  = a_valid && a_ready;
   assign b_push  = b_valid && b_ready;

   assign a_din.oob   = ({1'b0, a_input} >= DEPTH_V);
   assign a_din.cache = overlap_cache_we;
   assign a_din.mem   = int_mem_we;
   assign a_din.addr  = a_input[AW-1:0];

   assign pop = !a_empty && !b_empty && (!wr_valid || wr_ready);

   // During drain no more beats arrive, so a lone entry can never pair.
   assign flush_a = (state == DRAIN) && !a_empty && b_empty;
   assign flush_b = (state == DRAIN) && a_empty && !b_empty;

   ab_fifo2 #(.W($bits(a_ent_t))) u_afifo (
      .clk(clk), .rst(rst), .flush(flush_a), .push(a_push), .din(a_din),
      .pop(pop), .dout(a_head), .empty(a_empty), .full(a_full)
   );

   ab_fifo2 #(.W(DATA_WIDTH)) u_bfifo (
      .clk(clk), .rst(rst), .flush(flush_b), .push(b_push), .din(b_input),
      .pop(pop), .dout(b_head), .empty(b_empty), .full(b_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         wr_valid     <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_mem       <= 1'b0;
         wr_cache     <= 1'b0;
         load_done    <= 1'b0;
         pair_count   <= '0;
         addr_err     <= 1'b0;
         unpaired_err <= 1'b0;
      end else begin
         load_done <= 1'b0;

         // Dropped pairs still pop and count, they just leave wr_valid low.
         if (pop) begin
            wr_valid <= !a_head.oob && (a_head.mem || a_head.cache);
            wr_addr  <= a_head.addr;
            wr_data  <= b_head;
            wr_mem   <= a_head.mem;
            wr_cache <= a_head.cache;
            if (pair_count != '1) pair_count <= pair_count + CNT_WIDTH'(1);
            if (a_head.oob) addr_err <= 1'b1;
         end else if (wr_ready) begin
            wr_valid <= 1'b0;
         end

         if (flush_a || flush_b) unpaired_err <= 1'b1;

         case (state)
            LOAD:  if (data_ready) state <= DRAIN;
            DRAIN: if (a_empty && b_empty && !wr_valid) begin
                      load_done <= 1'b1;
                      state     <= DONE;
                   end
            DONE:  if (!data_ready) state <= LOAD;
            default: state <= LOAD;
         endcase
      end
   end
endmodule
